// File: rtl/sync_dual_port_ram.sv
// Single-clock simple dual-port RAM: registered read (1 or 2 cycles), byte-lane
// write enables, selectable read-during-write policy and a post-reset clear sweep.
module sync_dual_port_ram #(
  parameter int unsigned             DATA_WIDTH   = 16,
  parameter int unsigned             BYTE_WIDTH   = 8,
  parameter int unsigned             NUM_LANES    = DATA_WIDTH / BYTE_WIDTH,
  parameter int unsigned             DEPTH        = 10,
  parameter int unsigned             ADDR_WIDTH   = $clog2(DEPTH),
  parameter int unsigned             READ_LATENCY = 1,
  parameter int unsigned             RDW_MODE     = 0,
  parameter logic [DATA_WIDTH-1:0]   INIT_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [NUM_LANES-1:0]  wr_be,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  addr_err
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                r_state;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  r_addr_err;

  logic                  w_wr_inrange;
  logic                  w_rd_inrange;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_wr_inrange = (32'(wr_addr) < DEPTH);
  assign w_rd_inrange = (32'(rd_addr) < DEPTH);
  assign w_wr_ok      = !r_busy && wr_en && w_wr_inrange;
  assign w_rd_ok      = !r_busy && rd_en;
  assign w_err        = !r_busy && ((wr_en && !w_wr_inrange) || (rd_en && !w_rd_inrange));

  // Out-of-range reads return INIT_VALUE; write-through merges only enabled lanes.
  always_comb begin
    w_rd_word = INIT_VALUE;
    if (w_rd_inrange) begin
      w_rd_word = r_mem[rd_addr];
      if ((RDW_MODE != 0) && w_wr_ok && (wr_addr == rd_addr)) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          if (wr_be[i]) begin
            w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_busy    <= 1'b1;
      r_clr_ptr <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_clr_ptr <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
          end
        end
        ST_IDLE: begin
          if (clr) begin
            r_state   <= ST_CLEAR;
            r_busy    <= 1'b1;
            r_clr_ptr <= '0;
          end
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_busy    <= 1'b1;
          r_clr_ptr <= '0;
        end
      endcase
    end
  end

  // Storage has no reset; it is initialised only by the sweep.
  always_ff @(posedge clk) begin
    if (r_busy) begin
      r_mem[r_clr_ptr] <= INIT_VALUE;
    end else if (w_wr_ok) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (wr_be[i]) begin
          r_mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_ok;
      r_addr_err <= w_err;
      if (w_rd_ok) begin
        r_s1_data <= w_rd_word;
      end
    end
  end

  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic                  r_s2_valid;
      logic [DATA_WIDTH-1:0] r_s2_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign rd_valid = r_s2_valid;
      assign rd_data  = r_s2_data;
    end else begin : g_lat1
      assign rd_valid = r_s1_valid;
      assign rd_data  = r_s1_data;
    end
  endgenerate

  assign busy     = r_busy;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_sync_dual_port_ram.sv
// Directed bench for sync_dual_port_ram: instance A (latency 1, old-data RDW)
// and instance B (latency 2, write-through RDW) share all stimulus.
module tb_sync_dual_port_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_be = '0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic        busy_a, rd_valid_a, addr_err_a;
  logic [15:0] rd_data_a;
  logic        busy_b, rd_valid_b, addr_err_b;
  logic [15:0] rd_data_b;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_mem [10];

  always #5 clk = ~clk;

  sync_dual_port_ram #(.READ_LATENCY(1), .RDW_MODE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .addr_err(addr_err_a)
  );

  sync_dual_port_ram #(.READ_LATENCY(2), .RDW_MODE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_b),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .addr_err(addr_err_b)
  );

  task automatic do_write(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0; wr_be = '0;
  endtask

  task automatic do_read(input string name, input logic [3:0] addr,
                         input logic [15:0] ea, input logic [15:0] eb);
    rd_en = 1'b1; rd_addr = addr;
    @(negedge clk);
    rd_en = 1'b0;
    n_cmp++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== ea)
      $display("FAIL %s A lat1: valid=%b data=%h, need valid=1 data=%h", name, rd_valid_a, rd_data_a, ea);
    n_cmp++;
    if (rd_valid_b !== 1'b0)
      $display("FAIL %s B early: valid=%b, need 0", name, rd_valid_b);
    if (rd_valid_a !== 1'b1 || rd_data_a !== ea || rd_valid_b !== 1'b0) n_fail++;
    @(negedge clk);
    n_cmp++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== eb) begin
      n_fail++;
      $display("FAIL %s B lat2: valid=%b data=%h, need valid=1 data=%h", name, rd_valid_b, rd_data_b, eb);
    end
    n_cmp++;
    if (rd_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL %s A pulse: valid=%b, need 0", name, rd_valid_a);
    end
  endtask

  task automatic test_reset();
    int cnt;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: a=%b b=%b, need 1", busy_a, busy_b);
    end
    n_cmp++;
    if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 || addr_err_a !== 1'b0 || addr_err_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: va=%b vb=%b ea=%b eb=%b, need 0", rd_valid_a, rd_valid_b, addr_err_a, addr_err_b);
    end
    n_cmp++;
    if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data: a=%h b=%h, need 0000", rd_data_a, rd_data_b);
    end
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy_a) break;
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== 10) begin
      n_fail++; $display("FAIL reset_sweep_len: busy cycles=%0d, need 10", cnt);
    end
    for (int i = 0; i < 10; i++) begin
      exp_mem[i] = 16'h0000;
      do_read("reset_read", 4'(i), 16'h0000, 16'h0000);
    end
  endtask

  task automatic test_byte_enables();
    do_write(4'd3, 16'hAAAA, 2'b11);
    do_write(4'd3, 16'h1234, 2'b01);
    exp_mem[3] = 16'hAA34;
    do_read("byte_enable", 4'd3, 16'hAA34, 16'hAA34);
  endtask

  task automatic test_rdw();
    do_write(4'd5, 16'h1111, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h2222; wr_be = 2'b10;
    rd_en = 1'b1; rd_addr = 4'd5;
    @(negedge clk);
    wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
    n_cmp++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h1111) begin
      n_fail++; $display("FAIL rdw_old: valid=%b data=%h, need 1/1111", rd_valid_a, rd_data_a);
    end
    @(negedge clk);
    n_cmp++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 16'h2211) begin
      n_fail++; $display("FAIL rdw_new: valid=%b data=%h, need 1/2211", rd_valid_b, rd_data_b);
    end
    exp_mem[5] = 16'h2211;
    do_read("rdw_after", 4'd5, 16'h2211, 16'h2211);
    do_write(4'd6, 16'h5A5A, 2'b11);
    exp_mem[6] = 16'h5A5A;
    do_read("write_then_read", 4'd6, 16'h5A5A, 16'h5A5A);
  endtask

  task automatic test_out_of_range();
    do_write(4'd12, 16'hBEEF, 2'b11);
    n_cmp++;
    if (addr_err_a !== 1'b1 || addr_err_b !== 1'b1) begin
      n_fail++; $display("FAIL oor_wr_err: a=%b b=%b, need 1", addr_err_a, addr_err_b);
    end
    @(negedge clk);
    n_cmp++;
    if (addr_err_a !== 1'b0 || addr_err_b !== 1'b0) begin
      n_fail++; $display("FAIL oor_wr_pulse: a=%b b=%b, need 0", addr_err_a, addr_err_b);
    end
    for (int i = 0; i < 10; i++)
      do_read("oor_unchanged", 4'(i), exp_mem[i], exp_mem[i]);
    do_read("oor_pre", 4'd3, 16'hAA34, 16'hAA34);
    rd_en = 1'b1; rd_addr = 4'd15;
    @(negedge clk);
    rd_en = 1'b0;
    n_cmp++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h0000 || addr_err_a !== 1'b1 || addr_err_b !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_rd_a: valid=%b data=%h err_a=%b err_b=%b, need 1/0000/1/1", rd_valid_a, rd_data_a, addr_err_a, addr_err_b);
    end
    @(negedge clk);
    n_cmp++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 16'h0000 || addr_err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_rd_b: valid=%b data=%h err_a=%b, need 1/0000/0", rd_valid_b, rd_data_b, addr_err_a);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 10; i++) begin
      do_write(4'(i), 16'hA000 + 16'(i), 2'b11);
      exp_mem[i] = 16'hA000 + 16'(i);
    end
    for (int c = 0; c < 23; c++) begin
      n_cmp++;
      if (c >= 1 && c <= 20) begin
        if (rd_valid_a !== 1'b1 || rd_data_a !== exp_mem[(c-1) % 10]) begin
          n_fail++; $display("FAIL stream_a[%0d]: valid=%b data=%h, need 1/%h", c, rd_valid_a, rd_data_a, exp_mem[(c-1) % 10]);
        end
      end else if (rd_valid_a !== 1'b0) begin
        n_fail++; $display("FAIL stream_a_idle[%0d]: valid=%b, need 0", c, rd_valid_a);
      end
      n_cmp++;
      if (c >= 2 && c <= 21) begin
        if (rd_valid_b !== 1'b1 || rd_data_b !== exp_mem[(c-2) % 10]) begin
          n_fail++; $display("FAIL stream_b[%0d]: valid=%b data=%h, need 1/%h", c, rd_valid_b, rd_data_b, exp_mem[(c-2) % 10]);
        end
      end else if (rd_valid_b !== 1'b0) begin
        n_fail++; $display("FAIL stream_b_idle[%0d]: valid=%b, need 0", c, rd_valid_b);
      end
      rd_en   = (c < 20);
      rd_addr = 4'(c % 10);
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_clear();
    int cnt;
    for (int i = 0; i < 10; i++) do_write(4'(i), 16'hFFFF, 2'b11);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd12;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy_a) break;
      cnt++;
      n_cmp++;
      if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 || addr_err_a !== 1'b0 || addr_err_b !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_ignore[%0d]: va=%b vb=%b ea=%b eb=%b, need 0", c, rd_valid_a, rd_valid_b, addr_err_a, addr_err_b);
      end
      clr = (c == 3);
      @(negedge clk);
    end
    clr = 1'b0; wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
    n_cmp++;
    if (cnt !== 10 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL clear_len: busy cycles=%0d busy_b=%b, need 10/0", cnt, busy_b);
    end
    for (int i = 0; i < 10; i++) do_read("clear_read", 4'(i), 16'h0000, 16'h0000);
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    for (int i = 0; i < 10; i++) do_write(4'(i), 16'h0F0F, 2'b11);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy_a !== 1'b1 || rd_valid_a !== 1'b0 || rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_state: busy=%b valid=%b da=%h db=%h, need 1/0/0000/0000", busy_a, rd_valid_a, rd_data_a, rd_data_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy_a) break;
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== 10) begin
      n_fail++; $display("FAIL midreset_len: busy cycles=%0d, need 10", cnt);
    end
    for (int i = 0; i < 10; i++) do_read("midreset_read", 4'(i), 16'h0000, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_byte_enables();
    test_rdw();
    test_out_of_range();
    test_streaming();
    test_clear();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_dual_port_ram.md
# sync_dual_port_ram

Single-clock simple dual-port RAM with registered read, per-lane byte write enables, selectable read latency and read-during-write policy, and a hardware clear sequencer that initialises every word after reset or on request. It is the synchronous, parametrised successor to the async FIFO's storage array. It is intended for single-clock FIFOs, line buffers and register-file style storage, where a combinational read path and a reset-driven memory wipe are not acceptable.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane
- NUM_LANES, DATA_WIDTH/BYTE_WIDTH, derived lane count
- DEPTH, 10, number of words; need not be a power of two
- ADDR_WIDTH, $clog2(DEPTH), address width
- READ_LATENCY, 1, 1 or 2 cycles from rd_en to rd_valid
- RDW_MODE, 0, same-address read during write: 0 returns old data, 1 returns new (write-through)
- INIT_VALUE, 0, word value written by the clear sequencer
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  one-cycle request to re-run the clear sweep
- busy  out  1  high while the clear sweep runs; all accesses ignored
- wr_en  in  1  write strobe
- wr_be  in  NUM_LANES  per-lane write enable
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data, held between reads
- rd_valid  out  1  one-cycle pulse qualifying rd_data
- addr_err  out  1  one-cycle pulse: an accepted access used an address >= DEPTH

## Operation
- FSM states:
  - CLEAR: writes INIT_VALUE to clr_ptr, one word per cycle, ascending from 0 to DEPTH-1.
  - IDLE: normal accesses.
- FSM transitions:
  - CLEAR -> IDLE after the write to DEPTH-1.
  - IDLE -> CLEAR on clr; clr_ptr reloads to 0.
  - clr while in CLEAR is ignored. The sweep does not restart.
- Reset:
  - Reset does not touch the memory array. Storage is cleared only by the sweep.
  - Asserting rst_n low forces CLEAR with clr_ptr=0, busy=1, rd_data=0, rd_valid=0, addr_err=0, and empties the read pipeline.
  - Reset mid-sweep restarts the sweep from address 0.
- During busy:
  - wr_en and rd_en are ignored: no write, no rd_valid, no addr_err.
  - rd_data holds its value.
- Writes (IDLE, wr_en=1, wr_addr<DEPTH):
  - For each lane i with wr_be[i]=1, mem[wr_addr] lane i takes wr_data lane i.
  - Other lanes are unchanged.
  - wr_be all zero writes nothing and is not an error.
- Reads (IDLE, rd_en=1, rd_addr<DEPTH): the word is fetched into the read pipeline.
- Out of range (address >= DEPTH, only possible when DEPTH is not a power of two):
  - A write is dropped.
  - A read returns INIT_VALUE with rd_valid asserted.
  - addr_err pulses aligned with the access cycle +1. Read and write errors in the same cycle give one pulse.
- Simultaneous read and write, same address:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the merged word, with enabled lanes from wr_data and the rest old.
- Different addresses in the same cycle are fully independent.

## Timing
- Sweep:
  - busy deasserts on the edge after the write to DEPTH-1, i.e. DEPTH cycles after rst_n release.
  - The first accepted access is in the cycle busy reads 0.
- Read latency, with rd_en sampled at edge k:
  - READ_LATENCY=1: rd_data and rd_valid are updated at edge k+1.
  - READ_LATENCY=2: an internal data register is added, and the update occurs at edge k+2.
  - Back-to-back reads give one result per cycle at full throughput.
- rd_valid is a single-cycle pulse per accepted read. rd_data changes only when rd_valid is asserted.
- Write data is visible to a read of the same address issued on the next cycle, under either RDW_MODE.
- clr accepted at edge k sets busy at edge k+1. Reads already in the pipeline still complete and pulse rd_valid.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset release, DEPTH=10:
  - busy=1 for exactly 10 cycles, then 0.
  - Reading addresses 0..9 returns 0x0000, each with rd_valid, at latency READ_LATENCY.
- Byte enables:
  - Write 0xAAAA to addr 3 with be=11, then 0x1234 with be=01.
  - A read of addr 3 returns 0xAA34.
- Read during write, addr 5 holding 0x1111, write 0x2222 with be=10 and read in the same cycle:
  - RDW_MODE=0 returns 0x1111.
  - RDW_MODE=1 returns 0x2211.
  - The next read returns 0x2211.
- Out of range:
  - A write to addr 12 leaves all words unchanged and pulses addr_err once.
  - A read of addr 15 returns 0x0000 with rd_valid and addr_err.
- Clear and reset interaction:
  - Fill all words with 0xFFFF, pulse clr, and pulse clr again 3 cycles later. busy stays high for exactly 10 cycles.
  - Drop rst_n mid-sweep. busy stays 1 and the sweep completes 10 cycles after release.
  - After the sweep, every read returns 0x0000.
- Streaming:
  - 20 back-to-back reads with READ_LATENCY=2 produce 20 consecutive rd_valid pulses, starting 2 cycles after the first rd_en, with data in order.
